// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared definitions for the sequential FIR filter: controller state
//   encoding and the default widths used by fir_filter, fir_dp and fir_sm.
//   No ports; imported with "import fir_pkg::*".
package fir_pkg;

  // Default geometry: 16-bit samples and coefficients, 64 taps, and an
  // accumulator wide enough that a full 64-term sum can never overflow.
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_COEFF_COUNT = 64;
  localparam int ADDR_W          = $clog2(DEF_COEFF_COUNT);
  localparam int DEF_OUT_WIDTH   = 2 * DEF_DATA_WIDTH + ADDR_W;

  // Controller states. One MULT/ADD pair is spent per tap.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MULT = 3'd2,
    ADD  = 3'd3,
    DONE = 3'd4
  } fir_state_t;

endpackage

// File: rtl/fir_dp.sv
// fir_dp
//   Datapath of the sequential FIR filter: sample delay line, coefficient
//   ROM, one shared signed multiplier, product register, one shared adder
//   and the accumulator/output register. All sequencing comes from fir_sm.
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active low
//   in        in   signed input sample
//   dp_rst    in   clear the accumulator at the start of a sweep
//   ld_in     in   shift `in` into the delay line (newest at index 0)
//   ld_prod   in   register coeff[address] * shreg[address]
//   ld_out    in   accumulate: out <= out + prod
//   address   in   tap index for this multiply
//   out       out  signed accumulator (final sum when output_valid is high)
module fir_dp
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int COEFF_COUNT = DEF_COEFF_COUNT,
  parameter     COEFF_FILE  = "",
  parameter int AW          = $clog2(COEFF_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in,
  input  logic                         dp_rst,
  input  logic                         ld_in,
  input  logic                         ld_prod,
  input  logic                         ld_out,
  input  logic        [AW-1:0]         address,
  output logic signed [OUT_WIDTH-1:0]  out
);

  logic signed [DATA_WIDTH-1:0]   shreg [COEFF_COUNT];
  logic signed [DATA_WIDTH-1:0]   coeff_rom [COEFF_COUNT];
  logic signed [DATA_WIDTH-1:0]   shreg_out;
  logic signed [DATA_WIDTH-1:0]   coeff_out;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [OUT_WIDTH-1:0]    mult_out;
  logic signed [OUT_WIDTH-1:0]    adder_out;
  logic signed [OUT_WIDTH-1:0]    prod;

  // Coefficient ROM. The taps are the ramp 1, 2, 3, ...
  // which makes every result easy to work out by hand.
  for (genvar k = 0; k < COEFF_COUNT; k++) begin : g_tap
    assign coeff_rom[k] = DATA_WIDTH'(k + 1);
  end

  // Both operands are read through the same address, so the multiplier sees
  // the coefficient and the sample that belong to the same tap.
  assign shreg_out = shreg[address];
  assign coeff_out = coeff_rom[address];
  assign product   = coeff_out * shreg_out;
  assign mult_out  = OUT_WIDTH'(product);
  assign adder_out = out + prod;

  // Delay line. A reset wipes the sample history as well, so the first
  // result after reset only contains the newest sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < COEFF_COUNT; k++) begin
        shreg[k] <= '0;
      end
    end else if (ld_in) begin
      shreg[0] <= in;
      for (int k = 1; k < COEFF_COUNT; k++) begin
        shreg[k] <= shreg[k-1];
      end
    end
  end

  // Product register: splits the multiply and the add into separate clocks
  // so each state only has one arithmetic operation on its path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod <= '0;
    end else if (ld_prod) begin
      prod <= mult_out;
    end
  end

  // Accumulator. It is cleared when a new sample is loaded and then holds
  // its final value until the next sample arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else if (dp_rst) begin
      out <= '0;
    end else if (ld_out) begin
      out <= adder_out;
    end
  end

endmodule

// File: rtl/fir_sm.sv
// fir_sm
//   Controller of the sequential FIR filter. It walks the tap counter through
//   one MULT/ADD pair per tap and raises output_valid when the sum is done.
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active low
//   input_valid   in   sample strobe, only looked at in IDLE
//   dp_rst        out  clear accumulator (LOAD)
//   ld_in         out  shift the sample into the delay line (LOAD)
//   ld_prod       out  register the product (MULT)
//   ld_out        out  accumulate the product (ADD)
//   cen           out  advance the tap counter (MULT)
//   address       out  current tap index
//   output_valid  out  result ready, held until the next accepted sample
module fir_sm
  import fir_pkg::*;
#(
  parameter int COEFF_COUNT = DEF_COEFF_COUNT,
  parameter int AW          = $clog2(COEFF_COUNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          input_valid,
  output logic          dp_rst,
  output logic          ld_in,
  output logic          ld_prod,
  output logic          ld_out,
  output logic          cen,
  output logic [AW-1:0] address,
  output logic          output_valid
);

  // One extra bit so the counter can reach COEFF_COUNT after the last
  // multiply; the address itself never wraps inside a sweep.
  logic [AW:0] count;
  fir_state_t  state_q;
  fir_state_t  state_d;
  logic        done_q;

  assign address = count[AW-1:0];

  // State, tap counter and the result flag. The flag is raised one clock
  // after DONE so output_valid rises 131 edges after the sampled strobe,
  // and it drops as soon as the next sample is taken in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count        <= '0;
      done_q       <= 1'b0;
      output_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      if (state_q == LOAD) begin
        count <= '0;
      end else if (cen) begin
        count <= count + (AW+1)'(1);
      end
      if (state_q == LOAD) begin
        output_valid <= 1'b0;
      end else if (done_q) begin
        output_valid <= 1'b1;
      end
    end
  end

  // Next-state and control strobes. A strobe arriving outside IDLE is simply
  // dropped; there is no queueing of samples.
  always_comb begin
    state_d = state_q;
    dp_rst  = 1'b0;
    ld_in   = 1'b0;
    ld_prod = 1'b0;
    ld_out  = 1'b0;
    cen     = 1'b0;
    case (state_q)
      IDLE: begin
        if (input_valid) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        dp_rst  = 1'b1;
        ld_in   = 1'b1;
        state_d = MULT;
      end
      MULT: begin
        ld_prod = 1'b1;
        cen     = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        ld_out = 1'b1;
        if (count < (AW+1)'(COEFF_COUNT)) begin
          state_d = MULT;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/fir_filter.sv
// fir_filter
//   Sequential 64-tap FIR filter. Each accepted sample enters the delay line
//   and the sum of coeff[k]*shreg[k] is built one tap at a time with a single
//   shared multiplier and adder (two clocks per tap).
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active low
//   in            in   signed input sample
//   input_valid   in   sample strobe, honoured only while idle
//   out           out  signed filter result (partial sums while busy)
//   output_valid  out  out holds a finished result
module fir_filter
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int COEFF_COUNT = DEF_COEFF_COUNT,
  parameter     COEFF_FILE  = ""
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in,
  input  logic                         input_valid,
  output logic signed [OUT_WIDTH-1:0]  out,
  output logic                         output_valid
);

  localparam int AW = $clog2(COEFF_COUNT);

  logic          dp_rst;
  logic          ld_in;
  logic          ld_prod;
  logic          ld_out;
  logic          cen;
  logic [AW-1:0] address;

  fir_sm #(
    .COEFF_COUNT (COEFF_COUNT),
    .AW          (AW)
  ) u_sm (
    .clk          (clk),
    .rst          (rst),
    .input_valid  (input_valid),
    .dp_rst       (dp_rst),
    .ld_in        (ld_in),
    .ld_prod      (ld_prod),
    .ld_out       (ld_out),
    .cen          (cen),
    .address      (address),
    .output_valid (output_valid)
  );

  fir_dp #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .COEFF_COUNT (COEFF_COUNT),
    .COEFF_FILE  (COEFF_FILE),
    .AW          (AW)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .dp_rst  (dp_rst),
    .ld_in   (ld_in),
    .ld_prod (ld_prod),
    .ld_out  (ld_out),
    .address (address),
    .out     (out)
  );

endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter
//   Randomised bench for fir_filter with the default ramp ROM (coeff[k]=k+1).
//   The stimulus process keeps a sample history, works out each expected
//   sum and acceptance edge, and queues them; a monitor compares whenever
//   output_valid rises.
module tb_fir_filter;

  localparam int DW         = 16;
  localparam int OW         = 38;
  localparam int TAPS       = 64;
  localparam int LATENCY    = 131;
  localparam int WAIT_LIMIT = 400;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] in_sample = '0;
  logic                 input_valid = 1'b0;
  logic signed [OW-1:0] out;
  logic                 output_valid;

  typedef struct {
    logic signed [OW-1:0] value;
    int unsigned          accept_edge;
  } exp_t;

  exp_t        sb_q[$];
  int          history[TAPS];
  int          check_count = 0;
  int          pass_count  = 0;
  int unsigned edge_cnt    = 0;

  fir_filter dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in_sample),
    .input_valid  (input_valid),
    .out          (out),
    .output_valid (output_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    check_count++;
    if (actual == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: plain convolution over the stored history, newest first.
  function automatic logic signed [OW-1:0] model_push(input int sample);
    longint acc;
    for (int k = TAPS - 1; k > 0; k--) history[k] = history[k-1];
    history[0] = sample;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(k + 1) * longint'(history[k]);
    return OW'(acc);
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < TAPS; k++) history[k] = 0;
  endfunction

  // Called at a negedge while the filter is idle; hold is 1 or 2 clocks.
  task automatic applyStimulus(input logic signed [DW-1:0] sample, input int hold);
    exp_t e;
    in_sample   = sample;
    input_valid = 1'b1;
    e.accept_edge = edge_cnt + 1;
    e.value       = model_push(int'(sample));
    sb_q.push_back(e);
    repeat (hold) @(negedge clk);
    input_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(negedge clk);
      if (i == 4) in_sample = DW'($urandom);
      if (sb_q.size() == 0) return;
    end
    check_count++;
    $display("[TB] FAIL timeout: output_valid not seen within %0d clocks, %0d pending",
             WAIT_LIMIT, sb_q.size());
    sb_q.delete();
  endtask

  // Monitor: a rising output_valid must match the oldest queued expectation,
  // arrive exactly LATENCY edges after acceptance and still be high one
  // clock later.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && output_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          check_count++;
          $display("[TB] FAIL spurious: output_valid rose with out=%0d, expected no result", out);
        end else begin
          e = sb_q.pop_front();
          checkOutput("result", out, e.value);
          checkOutput("latency", 64'(edge_cnt - e.accept_edge), 64'(LATENCY));
          @(negedge clk);
          checkOutput("valid_held", 64'(output_valid), 64'd1);
        end
      end
      prev_valid = output_valid;
    end
  end

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    checkOutput("reset_out", out, 0);
    checkOutput("reset_valid", 64'(output_valid), 0);
    rst = 1'b1;
    @(negedge clk);

    // Hand-checkable sequence: 293, 4187, 10286.
    applyStimulus(16'h0125, 1); wait_drain();
    applyStimulus(16'h0E11, 1); wait_drain();
    applyStimulus(16'h089D, 2); wait_drain();

    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(DW'($urandom), int'($urandom_range(1, 2)));
      wait_drain();
    end

    // Most negative sample, then reset in the middle of its sweep.
    applyStimulus(16'h8000, 1);
    repeat (60) @(negedge clk);
    checkOutput("busy_valid", 64'(output_valid), 0);
    rst = 1'b0;
    #1;
    checkOutput("midreset_out", out, 0);
    checkOutput("midreset_valid", 64'(output_valid), 0);
    sb_q.delete();
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // History was wiped: the result is just the sample times coeff[0].
    applyStimulus(16'h1234, 1); wait_drain();
    applyStimulus(DW'($urandom), 2); wait_drain();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
